// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int DEFAULT_ADDR_W = 7;
    localparam int DEFAULT_DATA_W = 16;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        LATCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/pc_counter.sv
// Program counter: load has priority over increment; increment wraps modulo 2^ADDR_W.
module pc_counter #(
    parameter int                ADDR_W   = 7,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: drives the synchronous ROM, latches the IR and
// hands instructions to decode over a valid/ready handshake.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = DEFAULT_ADDR_W,
    parameter int                DATA_W   = DEFAULT_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              halted
);

    fetch_state_t      state;
    fetch_state_t      next_state;
    logic [ADDR_W-1:0] pc;
    logic              pc_inc;
    logic              ir_load;

    // A redirect in LATCH drops the ROM word, so neither the IR nor the PC advance.
    assign ir_load  = (state == LATCH) && !redirect;
    assign pc_inc   = ir_load;
    assign rom_addr = pc;

    pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_counter (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (redirect),
        .load_val (redirect_pc),
        .inc      (pc_inc),
        .pc       (pc)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            FETCH:   next_state = halt ? HALT : LATCH;
            LATCH:   next_state = HOLD;
            HOLD:    next_state = ir_ready ? FETCH : HOLD;
            HALT:    next_state = halt ? HALT : FETCH;
            default: next_state = FETCH;
        endcase
        if (redirect) begin
            next_state = FETCH;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            halted <= (next_state == HALT);
            if (ir_load) begin
                ir       <= rom_q;
                ir_pc    <= pc;
                ir_valid <= 1'b1;
            end else if (redirect || ((state == HOLD) && ir_ready)) begin
                ir_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus pushes expected {ir, ir_pc}
// pairs; a negedge monitor pops one on every accepted handshake.
module tb_fetch_sequencer;

    typedef struct {
        logic [15:0] word;
        logic [6:0]  addr;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic [6:0]  rom_addr;
    logic [15:0] rom_q;
    logic [15:0] ir;
    logic [6:0]  ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect;
    logic [6:0]  redirect_pc;
    logic        halt;
    logic        halted;

    logic [15:0] mem [128];
    exp_t        sb_q [$];
    int          n_compared = 0;
    int          n_failed   = 0;

    fetch_sequencer #(
        .ADDR_W   (7),
        .DATA_W   (16),
        .RESET_PC (7'h00)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .halted      (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous ROM with one-cycle registered read.
    always @(posedge clock) rom_q <= mem[rom_addr];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void push(logic [15:0] word, logic [6:0] addr);
        exp_t e;
        e.word = word;
        e.addr = addr;
        sb_q.push_back(e);
    endfunction

    always @(negedge clock) begin
        if (reset_n && ir_valid && ir_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_accept", {25'd0, ir_pc}, 32'h0);
                check("unexpected_accept_flag", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_ir", {16'd0, ir}, {16'd0, e.word});
                check("sb_ir_pc", {25'd0, ir_pc}, {25'd0, e.addr});
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!ir_valid && n < 20) begin
            step();
            n++;
        end
        check("wait_valid", {31'd0, ir_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        mem[0] = 16'h1A2B;
        for (int unsigned i = 1; i < 128; i++) mem[i] = 16'h5000 + 16'(i) * 16'h0101;

        reset_n     = 1'b0;
        ir_ready    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 7'h00;
        halt        = 1'b0;
        repeat (3) step();

        check("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
        check("rst_ir", {16'd0, ir}, 32'h0);
        check("rst_ir_pc", {25'd0, ir_pc}, 32'h0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_rom_addr", {25'd0, rom_addr}, 32'h0);

        // Reset release and first fetch
        ir_ready = 1'b1;
        push(16'h1A2B, 7'h00);
        reset_n = 1'b1;
        step();
        check("t1_edge1_valid", {31'd0, ir_valid}, 32'd0);
        check("t1_edge1_rom_addr", {25'd0, rom_addr}, 32'h0);
        step();
        check("t1_edge2_valid", {31'd0, ir_valid}, 32'd1);
        check("t1_edge2_ir", {16'd0, ir}, 32'h1A2B);
        check("t1_edge2_ir_pc", {25'd0, ir_pc}, 32'h0);
        check("t1_rom_addr_after", {25'd0, rom_addr}, 32'h1);
        step();

        // Back-pressure on word[1]
        ir_ready = 1'b0;
        push(16'h5101, 7'h01);
        step();
        step();
        check("t2_valid", {31'd0, ir_valid}, 32'd1);
        for (int unsigned i = 0; i < 5; i++) begin
            step();
            check("t2_hold_valid", {31'd0, ir_valid}, 32'd1);
            check("t2_hold_ir", {16'd0, ir}, 32'h5101);
            check("t2_hold_ir_pc", {25'd0, ir_pc}, 32'h01);
            check("t2_hold_rom_addr", {25'd0, rom_addr}, 32'h02);
        end
        ir_ready = 1'b1;
        push(16'h5202, 7'h02);
        step();
        check("t2_accept_clears", {31'd0, ir_valid}, 32'd0);
        wait_valid(n);
        check("t2_rearm_latency", n, 32'd2);
        step();

        // Wrap from 7'h7F to 7'h00
        redirect    = 1'b1;
        redirect_pc = 7'h7F;
        step();
        redirect = 1'b0;
        push(16'hCF7F, 7'h7F);
        push(16'h1A2B, 7'h00);
        wait_valid(n);
        step();
        wait_valid(n);
        step();
        check("t3_rom_addr_after_wrap", {25'd0, rom_addr}, 32'h01);

        // Redirect during LATCH of address 5
        redirect    = 1'b1;
        redirect_pc = 7'h05;
        step();
        redirect = 1'b0;
        step();
        redirect    = 1'b1;
        redirect_pc = 7'h40;
        step();
        redirect = 1'b0;
        check("t4_discard_valid", {31'd0, ir_valid}, 32'd0);
        check("t4_discard_ir", {16'd0, ir}, 32'h1A2B);
        check("t4_discard_ir_pc", {25'd0, ir_pc}, 32'h00);
        check("t4_rom_addr", {25'd0, rom_addr}, 32'h40);
        push(16'h9040, 7'h40);
        wait_valid(n);
        step();

        // Halt before FETCH, then resume at the same PC
        halt = 1'b1;
        step();
        check("t5_halted", {31'd0, halted}, 32'd1);
        for (int unsigned i = 0; i < 3; i++) begin
            step();
            check("t5_frozen_rom_addr", {25'd0, rom_addr}, 32'h41);
            check("t5_frozen_halted", {31'd0, halted}, 32'd1);
        end
        halt = 1'b0;
        step();
        check("t5_unhalted", {31'd0, halted}, 32'd0);
        push(16'h9141, 7'h41);
        wait_valid(n);
        step();

        // Redirect beats halt, FETCH re-enters HALT
        halt = 1'b1;
        step();
        check("t5b_halted", {31'd0, halted}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 7'h10;
        step();
        redirect = 1'b0;
        check("t5b_redirect_exit", {31'd0, halted}, 32'd0);
        check("t5b_rom_addr", {25'd0, rom_addr}, 32'h10);
        step();
        check("t5b_rehalt", {31'd0, halted}, 32'd1);
        check("t5b_rom_addr_held", {25'd0, rom_addr}, 32'h10);

        // Park word[0x10] in HOLD, then reset asynchronously between edges
        ir_ready = 1'b0;
        halt     = 1'b0;
        step();
        wait_valid(n);
        check("t6_hold_ir", {16'd0, ir}, 32'h6010);
        check("t6_hold_ir_pc", {25'd0, ir_pc}, 32'h10);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_ir_valid", {31'd0, ir_valid}, 32'd0);
        check("t6_async_ir", {16'd0, ir}, 32'h0);
        check("t6_async_ir_pc", {25'd0, ir_pc}, 32'h0);
        check("t6_async_halted", {31'd0, halted}, 32'd0);
        check("t6_async_rom_addr", {25'd0, rom_addr}, 32'h0);
        step();
        ir_ready = 1'b1;
        push(16'h1A2B, 7'h00);
        reset_n = 1'b1;
        wait_valid(n);
        check("t6_restart_latency", n, 32'd2);
        step();
        step();

        check("sb_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
